wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency execution unit (multi-cycle MUL/DIV) that returns results out of band. The pipeline WB stage has priority. A long-latency result waits for a free write slot. If it is blocked for too long, the arbiter stalls the pipeline for one cycle and forces the result in. The block sits between the writeback pipeline register / result mux and the register file write port.

---
 rtl/wb_port_arbiter_if.sv | 34 +++
 rtl/wb_port_arbiter.sv | 111 +++++++++++
 tb/tb_wb_port_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// ============================================================================
// wb_port_arbiter_if : write-port arbitration bundle (WB stage, LL unit, RF)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface wb_port_arbiter_if #(
  parameter int PERF_W = 16
);
  logic              RegWriteW;
  logic [4:0]        RdW;
  logic [31:0]       ResultW;
  logic              ll_valid;
  logic [4:0]        ll_rd;
  logic [31:0]       ll_data;
  logic              ll_ready;
  logic              rf_we;
  logic [4:0]        rf_rd;
  logic [31:0]       rf_wd;
  logic              stall_wb;
  logic [PERF_W-1:0] forced_cnt;

  modport master (
    output RegWriteW, RdW, ResultW, ll_valid, ll_rd, ll_data,
    input  ll_ready, rf_we, rf_rd, rf_wd, stall_wb, forced_cnt
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, ll_valid, ll_rd, ll_data,
    output ll_ready, rf_we, rf_rd, rf_wd, stall_wb, forced_cnt
  );
endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// wb_port_arbiter : shares the RF write port between the WB stage and a
//                   long-latency unit, forcing the LL result in after MAX_WAIT.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int PERF_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  localparam logic [3:0]        c_max_wait = 4'(MAX_WAIT);
  localparam logic [PERF_W-1:0] c_perf_max = '1;

  state_t            r_state;
  logic [3:0]        r_blk_cnt;
  logic [PERF_W-1:0] r_forced_cnt;

  logic              w_pipe_wr;
  logic              w_force;
  logic              w_grant_ll;
  logic              w_grant_pipe;
  logic              w_blocked;
  logic [3:0]        w_blk_inc;

  assign w_pipe_wr = bus.RegWriteW && (bus.RdW != 5'd0);
  assign w_force   = (r_state == ST_FORCE) && bus.ll_valid;
  // Outside FORCE the pipeline wins any conflict; in FORCE the LL unit wins.
  assign w_grant_ll   = w_force || (bus.ll_valid && !w_pipe_wr);
  assign w_grant_pipe = !w_grant_ll && w_pipe_wr;
  assign w_blocked    = bus.ll_valid && w_pipe_wr;
  assign w_blk_inc    = r_blk_cnt + 4'd1;

  // Write port is combinational so forwarding timing matches a plain RF.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_rd    = 5'd0;
    bus.rf_wd    = 32'd0;
    bus.ll_ready = 1'b0;
    bus.stall_wb = 1'b0;
    if (rst_n) begin
      if (w_grant_ll) begin
        bus.ll_ready = 1'b1;
        bus.rf_we    = (bus.ll_rd != 5'd0);
        bus.rf_rd    = bus.ll_rd;
        bus.rf_wd    = bus.ll_data;
        bus.stall_wb = w_force;
      end else if (w_grant_pipe) begin
        bus.rf_we = 1'b1;
        bus.rf_rd = bus.RdW;
        bus.rf_wd = bus.ResultW;
      end
    end
  end

  assign bus.forced_cnt = r_forced_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_blk_cnt    <= 4'd0;
      r_forced_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_blocked) begin
            r_blk_cnt <= 4'd1;
            r_state   <= (c_max_wait == 4'd1) ? ST_FORCE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A grant or a dropped request both end the starvation window.
          if (w_blocked) begin
            r_blk_cnt <= w_blk_inc;
            if (w_blk_inc == c_max_wait) begin
              r_state <= ST_FORCE;
            end
          end else begin
            r_blk_cnt <= 4'd0;
            r_state   <= ST_IDLE;
          end
        end
        ST_FORCE: begin
          r_blk_cnt <= 4'd0;
          r_state   <= ST_IDLE;
          if (w_force && (r_forced_cnt != c_perf_max)) begin
            r_forced_cnt <= r_forced_cnt + 1'b1;
          end
        end
        default: begin
          r_blk_cnt <= 4'd0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// tb_wb_port_arbiter : directed and randomized checks of wb_port_arbiter
//                      against a starvation-window reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        regw = 1'b0;
  logic [4:0]  rdw = 5'd0;
  logic [31:0] resw = 32'd0;
  logic        llv = 1'b0;
  logic [4:0]  llrd = 5'd0;
  logic [31:0] lld = 32'd0;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: consecutive blocked cycles and total forced grants
  int m_blk = 0;
  int m_forced = 0;
  bit last_ready = 1'b0;
  bit last_stall = 1'b0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.PERF_W(16)) bus ();
  wb_port_arbiter_if #(.PERF_W(2))  bus2 ();

  assign bus.RegWriteW  = regw;
  assign bus.RdW        = rdw;
  assign bus.ResultW    = resw;
  assign bus.ll_valid   = llv;
  assign bus.ll_rd      = llrd;
  assign bus.ll_data    = lld;
  assign bus2.RegWriteW = regw;
  assign bus2.RdW       = rdw;
  assign bus2.ResultW   = resw;
  assign bus2.ll_valid  = llv;
  assign bus2.ll_rd     = llrd;
  assign bus2.ll_data   = lld;

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT), .PERF_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT), .PERF_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Evaluate the model for the current inputs, compare both DUTs, then
  // advance the model to the state it holds after the coming rising edge.
  task automatic model_step();
    bit pw, frc, gll, gp;
    logic        e_we, e_rdy, e_stall;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    int          e_sat;
    pw  = regw && (rdw != 5'd0);
    frc = llv && (m_blk >= MAX_WAIT);
    gll = frc || (llv && !pw);
    gp  = !gll && pw;
    e_we = 1'b0; e_rd = 5'd0; e_wd = 32'd0; e_rdy = 1'b0; e_stall = 1'b0;
    if (rst_n) begin
      if (gll) begin
        e_rdy = 1'b1; e_we = (llrd != 5'd0); e_rd = llrd; e_wd = lld; e_stall = frc;
      end else if (gp) begin
        e_we = 1'b1; e_rd = rdw; e_wd = resw;
      end
    end
    e_sat = (m_forced > 3) ? 3 : m_forced;
    check_val("m_we",     64'(bus.rf_we),       64'(e_we));
    check_val("m_rd",     64'(bus.rf_rd),       64'(e_rd));
    check_val("m_wd",     64'(bus.rf_wd),       64'(e_wd));
    check_val("m_ready",  64'(bus.ll_ready),    64'(e_rdy));
    check_val("m_stall",  64'(bus.stall_wb),    64'(e_stall));
    check_val("m_fcnt",   64'(bus.forced_cnt),  64'(m_forced));
    check_val("m2_we",    64'(bus2.rf_we),      64'(e_we));
    check_val("m2_rd",    64'(bus2.rf_rd),      64'(e_rd));
    check_val("m2_ready", 64'(bus2.ll_ready),   64'(e_rdy));
    check_val("m2_stall", 64'(bus2.stall_wb),   64'(e_stall));
    check_val("m2_fcnt",  64'(bus2.forced_cnt), 64'(e_sat));
    last_ready = e_rdy;
    last_stall = e_stall;
    if (rst_n) begin
      if (frc) m_forced++;
      if (llv && !gll) m_blk++;
      else m_blk = 0;
    end
  endtask

  task automatic model_reset();
    m_blk = 0;
    m_forced = 0;
    last_ready = 1'b0;
    last_stall = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One starved LL request against a continuously writing pipeline.
  task automatic starve_once(input int tagn);
    regw = 1'b1; rdw = 5'd3; resw = 32'hA5A5_0000 + 32'(tagn);
    llv = 1'b1; llrd = 5'd9; lld = 32'hC0DE_0000 + 32'(tagn);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) begin
        check_val("starve_rd",    64'(bus.rf_rd),    64'd3);
        check_val("starve_ready", 64'(bus.ll_ready), 64'd0);
      end else if (c == 4) begin
        check_val("force_stall", 64'(bus.stall_wb), 64'd1);
        check_val("force_ready", 64'(bus.ll_ready), 64'd1);
        check_val("force_rd",    64'(bus.rf_rd),    64'd9);
      end else begin
        check_val("after_rd",    64'(bus.rf_rd),    64'd3);
        check_val("after_stall", 64'(bus.stall_wb), 64'd0);
      end
      model_step();
      next_cycle();
      if (c == 4) llv = 1'b0;
    end
  endtask

  initial begin
    // reset state with an active-looking pipeline write
    regw = 1'b1; rdw = 5'd5; resw = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("rst_we",    64'(bus.rf_we),      64'd0);
      check_val("rst_rd",    64'(bus.rf_rd),      64'd0);
      check_val("rst_fcnt",  64'(bus.forced_cnt), 64'd0);
      model_step();
    end
    next_cycle();
    rst_n = 1'b1;

    // idle port, pipeline write passes straight through
    @(negedge clk);
    check_val("pipe_we",    64'(bus.rf_we),    64'd1);
    check_val("pipe_rd",    64'(bus.rf_rd),    64'd5);
    check_val("pipe_wd",    64'(bus.rf_wd),    64'hDEAD_BEEF);
    check_val("pipe_ready", 64'(bus.ll_ready), 64'd0);
    check_val("pipe_stall", 64'(bus.stall_wb), 64'd0);
    model_step();
    next_cycle();

    // free slot goes to the LL unit
    regw = 1'b0; llv = 1'b1; llrd = 5'd7; lld = 32'h1234_5678;
    @(negedge clk);
    check_val("free_ready", 64'(bus.ll_ready), 64'd1);
    check_val("free_we",    64'(bus.rf_we),    64'd1);
    check_val("free_rd",    64'(bus.rf_rd),    64'd7);
    check_val("free_wd",    64'(bus.rf_wd),    64'h1234_5678);
    model_step();
    next_cycle();
    llv = 1'b0;

    starve_once(0);
    check_val("starve_fcnt", 64'(bus.forced_cnt), 64'd1);

    // x0 on the pipeline leaves the slot free; x0 on LL never writes
    regw = 1'b1; rdw = 5'd0; llv = 1'b1; llrd = 5'd4; lld = 32'h4444_4444;
    @(negedge clk);
    check_val("x0p_ready", 64'(bus.ll_ready), 64'd1);
    check_val("x0p_rd",    64'(bus.rf_rd),    64'd4);
    model_step();
    next_cycle();
    regw = 1'b0; llrd = 5'd0; lld = 32'h0BAD_0BAD;
    @(negedge clk);
    check_val("x0l_ready", 64'(bus.ll_ready), 64'd1);
    check_val("x0l_we",    64'(bus.rf_we),    64'd0);
    model_step();
    next_cycle();
    llv = 1'b0;

    // asynchronous reset two cycles into a wait window
    regw = 1'b1; rdw = 5'd3; llv = 1'b1; llrd = 5'd9; lld = 32'h9999_0001;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      model_step();
      next_cycle();
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_val("arst_we",    64'(bus.rf_we),      64'd0);
    check_val("arst_rd",    64'(bus.rf_rd),      64'd0);
    check_val("arst_wd",    64'(bus.rf_wd),      64'd0);
    check_val("arst_ready", 64'(bus.ll_ready),   64'd0);
    check_val("arst_stall", 64'(bus.stall_wb),   64'd0);
    check_val("arst_fcnt",  64'(bus.forced_cnt), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    starve_once(1);

    // saturating counter on the narrow instance
    rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      starve_once(k + 1);
      check_val("sat_fcnt2", 64'(bus2.forced_cnt), (k > 3) ? 64'd3 : 64'(k));
      check_val("sat_fcnt",  64'(bus.forced_cnt),  64'(k));
    end

    // randomized traffic with a handshake-respecting LL source
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall) begin
        regw = ($urandom_range(0, 3) != 0);
        rdw  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        resw = $urandom;
      end
      if (!llv || last_ready) begin
        llv  = ($urandom_range(0, 2) == 0);
        llrd = 5'($urandom_range(0, 31));
        lld  = $urandom;
      end else if ($urandom_range(0, 99) == 0) begin
        llv = 1'b0;
      end
      @(negedge clk);
      model_step();
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
